// File: rtl/cla_counter_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : cla_counter_sched_if
// Purpose  : Bundles the request/step/clear inputs and the count/ack/overflow
//            outputs of both counter channels.
//            master : the event-source side (drives req/step/clr)
//            slave  : the counter side (drives cnt/ack/ovf)
// Signals  : req0/req1   increment request, level-held until acknowledged
//            step0/step1 5-bit addend, sampled in the grant cycle
//            clr0/clr1   synchronous clear of the channel count
//            cnt0/cnt1   registered 5-bit counts
//            ack0/ack1   one-cycle pulse, request consumed
//            ovf0/ovf1   one-cycle pulse with ack, add produced carry-out
// Revision : 1.0 - initial release
// ============================================================================
interface cla_counter_sched_if;
    logic       req0;
    logic       req1;
    logic [4:0] step0;
    logic [4:0] step1;
    logic       clr0;
    logic       clr1;
    logic [4:0] cnt0;
    logic [4:0] cnt1;
    logic       ack0;
    logic       ack1;
    logic       ovf0;
    logic       ovf1;

    modport master (
        output req0, req1, step0, step1, clr0, clr1,
        input  cnt0, cnt1, ack0, ack1, ovf0, ovf1
    );

    modport slave (
        input  req0, req1, step0, step1, clr0, clr1,
        output cnt0, cnt1, ack0, ack1, ovf0, ovf1
    );
endinterface
`default_nettype wire

// File: rtl/cla_counter_sched.sv
`default_nettype none
// ============================================================================
// Module   : Carrylookahead
// Purpose  : 5-bit carry-lookahead adder. Every carry is formed directly
//            from the generate/propagate terms and cin (no ripple chain).
// Ports    : a, b (5-bit addends), cin, sum (5-bit), cout
// Revision : 1.0 - initial release
// ============================================================================
module Carrylookahead (
    input  wire logic [4:0] a,
    input  wire logic [4:0] b,
    input  wire logic       cin,
    output logic      [4:0] sum,
    output logic            cout
);
    localparam int c_W = 5;

    logic [c_W-1:0] w_g;
    logic [c_W-1:0] w_p;
    logic [c_W:0]   w_c;

    assign w_g = a & b;
    assign w_p = a ^ b;

    // c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]cin
    always_comb begin
        logic w_acc;
        logic w_prod;
        w_c    = '0;
        w_c[0] = cin;
        w_acc  = 1'b0;
        w_prod = 1'b1;
        for (int i = 0; i < c_W; i++) begin
            w_acc  = 1'b0;
            w_prod = 1'b1;
            for (int j = i; j >= 0; j--) begin
                w_acc  = w_acc | (w_prod & w_g[j]);
                w_prod = w_prod & w_p[j];
            end
            w_c[i+1] = w_acc | (w_prod & cin);
        end
    end

    for (genvar k = 0; k < c_W; k++) begin : g_sum
        assign sum[k] = w_p[k] ^ w_c[k];
    end

    assign cout = w_c[c_W];
endmodule

// ============================================================================
// Module   : cla_counter_sched
// Purpose  : Two-channel 5-bit event counter sharing one Carrylookahead adder.
//            A round-robin scheduler grants the adder to at most one channel
//            per cycle; the granted channel's count is updated and a
//            registered ack (with overflow flag) is returned the next cycle.
// Params   : SATURATE - 0: wrap modulo 32 on carry-out, 1: clamp to 31
// Ports    : clk, rst (synchronous, active-high)
//            bus (slave modport of cla_counter_sched_if): req/step/clr in,
//            cnt/ack/ovf out, all outputs registered
// Revision : 1.0 - initial release
// ============================================================================
module cla_counter_sched #(
    parameter int SATURATE = 0
) (
    input  wire logic          clk,
    input  wire logic          rst,
    cla_counter_sched_if.slave bus
);
    logic [4:0] r_cnt0;
    logic [4:0] r_cnt1;
    logic       r_ack0;
    logic       r_ack1;
    logic       r_ovf0;
    logic       r_ovf1;
    // Channel granted most recently (0 or 1); 1 after reset so ch0 wins
    // the first tie.
    logic       r_last;

    logic       w_elig0;
    logic       w_elig1;
    logic       w_gnt0;
    logic       w_gnt1;
    logic [4:0] w_a;
    logic [4:0] w_b;
    logic [4:0] w_sum;
    logic       w_cout;
    logic [4:0] w_next;

    // A channel sitting in its ack cycle is not eligible: the requester has
    // not yet had a chance to drop or renew its request.
    assign w_elig0 = bus.req0 & ~r_ack0;
    assign w_elig1 = bus.req1 & ~r_ack1;

    // On a tie, ch0 wins exactly when ch1 was the most recent grant.
    assign w_gnt0 = w_elig0 & (~w_elig1 | r_last);
    assign w_gnt1 = w_elig1 & ~w_gnt0;

    assign w_a = w_gnt1 ? r_cnt1    : r_cnt0;
    assign w_b = w_gnt1 ? bus.step1 : bus.step0;

    Carrylookahead u_cla (
        .a    (w_a),
        .b    (w_b),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    assign w_next = (w_cout && (SATURATE != 0)) ? 5'd31 : w_sum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt0 <= 5'd0;
            r_cnt1 <= 5'd0;
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            r_ovf0 <= 1'b0;
            r_ovf1 <= 1'b0;
            r_last <= 1'b1;
        end else begin
            // A clear overrides the count update but the grant is still
            // consumed (ack pulses, pointer moves); overflow is suppressed
            // since the sum was discarded.
            r_ack0 <= w_gnt0;
            r_ack1 <= w_gnt1;
            r_ovf0 <= w_gnt0 & w_cout & ~bus.clr0;
            r_ovf1 <= w_gnt1 & w_cout & ~bus.clr1;

            if (bus.clr0) begin
                r_cnt0 <= 5'd0;
            end else if (w_gnt0) begin
                r_cnt0 <= w_next;
            end

            if (bus.clr1) begin
                r_cnt1 <= 5'd0;
            end else if (w_gnt1) begin
                r_cnt1 <= w_next;
            end

            if (w_gnt0) begin
                r_last <= 1'b0;
            end else if (w_gnt1) begin
                r_last <= 1'b1;
            end
        end
    end

    assign bus.cnt0 = r_cnt0;
    assign bus.cnt1 = r_cnt1;
    assign bus.ack0 = r_ack0;
    assign bus.ack1 = r_ack1;
    assign bus.ovf0 = r_ovf0;
    assign bus.ovf1 = r_ovf1;
endmodule
`default_nettype wire
